cla_wide_add_ctrl: RTL and testbench
====================================

# cla_wide_add_ctrl

Sequencer that performs WIDTH-bit additions on the team's gate-level 8-bit carry-lookahead adder, one 8-bit slice at a time, least-significant slice first. It chains the slice carry-out through a carry register and assembles the result. It uses valid/ready handshakes on both sides. The controller sits between the requesting logic and an external 8-bit CLA instance; the wrapper `wide_cla_adder` instantiates both.

## Interface

Parameters:
- `WIDTH`, 32: operand width; multiple of 8, ≥ 8; `NSLICES = WIDTH/8`.
- `SLICE_CYCLES`, 1: cycles each slice is held on the CLA before capture, ≥ 1. This covers `nand*_delay` settling.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  controller can accept operands.
- `a`, `b`  in  WIDTH  operands.
- `cin`  in  1  carry into bit 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of bit WIDTH-1.
- `overflow`  out  1  two's-complement overflow.
- `busy`  out  1  state ≠ IDLE.
- `cla_a`, `cla_b`  out  8  slice operands to the CLA.
- `cla_cin`  out  1  slice carry-in.
- `cla_sum`  in  8  CLA sum.
- `cla_cout`  in  1  CLA carry-out.

## Operation

- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`:
    - latch `a`→`a_sh` and `b`→`b_sh`;
    - latch `a[WIDTH-1]`→`a_msb` and `b[WIDTH-1]`→`b_msb`;
    - set `carry`←`cin`, `idx`←0, `cnt`←0;
    - go to RUN.
- **RUN**
  - Drive `cla_a`=`a_sh[7:0]`, `cla_b`=`b_sh[7:0]`, `cla_cin`=`carry`.
  - Each cycle, `cnt`++.
  - When `cnt`==SLICE_CYCLES-1:
    - shift `sum_sh` right by 8, inserting `cla_sum` at `[WIDTH-1:WIDTH-8]`;
    - set `carry`←`cla_cout`;
    - shift `a_sh` and `b_sh` right by 8;
    - set `cnt`←0 and `idx`++.
  - If `idx`==NSLICES-1 at capture, go to DONE and register the outputs:
    - `sum` = final shifted value;
    - `cout`=`cla_cout`;
    - `overflow` = (`a_msb`==`b_msb`) && (`sum[WIDTH-1]`≠`a_msb`).
- **DONE**
  - `out_valid`=1; `sum`/`cout`/`overflow` are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in DONE, so there is no same-cycle re-accept. The next operation is accepted no earlier than the cycle after the result handshake.
- Outside RUN, `cla_a`/`cla_b`/`cla_cin` are driven 0.
- `in_valid` in RUN or DONE is ignored. Operand inputs are sampled only on the accept edge.
- `sum`/`cout`/`overflow` hold the last result after DONE until the next DONE entry. They are meaningful only while `out_valid`=1.
- Arithmetic is modulo 2^WIDTH. All carry propagation between slices is through `carry`; there is no other cross-slice path.

## Timing

- Reset (`rst_n`=0 at an edge), in any state including mid-RUN:
  - next state IDLE;
  - `sum`, `cout`, `overflow`, `out_valid`, `busy`, `cla_*` all 0;
  - `in_ready`=1 from the first cycle after reset;
  - in-flight operation discarded with no result.
- Latency: accept in cycle 0 → RUN for cycles 1..NSLICES·SLICE_CYCLES → `out_valid` first high in cycle NSLICES·SLICE_CYCLES+1 (5 for defaults).
- `cla_a`/`cla_b`/`cla_cin` change only on slice-capture edges. Each slice is held exactly SLICE_CYCLES cycles.
- Throughput: one operation per NSLICES·SLICE_CYCLES+2 cycles with `out_ready` tied high.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.

## Structure

- Package `cla_ctrl_pkg`:
  - `SLICE_W`=8;
  - state enum `cla_ctrl_state_t` {IDLE, RUN, DONE};
  - function `nslices(width)`.
- Sub-module `cla_slice_shifter`: operand and result shift registers with a shift-enable. The FSM, counters and carry register stay in `cla_wide_add_ctrl`.
- Elaboration check: WIDTH%8==0 and SLICE_CYCLES≥1; `$error` otherwise.

## Test plan

All with WIDTH=32 unless stated.
1. SLICE_CYCLES=1, a=0x00000001, b=0x00000002, cin=0 → sum=0x00000003, cout=0, overflow=0, `out_valid` in cycle 5.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0; `cla_cin`=1 on slices 1–3.
3. a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, overflow=1, cout=0. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, overflow=1.
4. Backpressure: `out_ready`=0 for 3 cycles in DONE → `out_valid`, `sum` stable, `in_ready`=0. A second `in_valid` pulse during RUN is not accepted.
5. `rst_n`=0 in the 2nd RUN cycle → next cycle IDLE, all outputs 0, `in_ready`=1. The next operation, a=0x12345678 + b=0x11111111, gives sum=0x23456789.
6. SLICE_CYCLES=3, a=0x00FF00FF, b=0x00010001, cin=1 → sum=0x01000101, cout=0. `cla_a` is held 3 cycles per slice, and `out_valid` appears in cycle 13.

Source files
------------

// File: rtl/cla_wide_add_ctrl_pkg.sv
// Shared types and constants for the sliced carry-lookahead add controller.
package cla_ctrl_pkg;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_ctrl_state_t;

  function automatic int nslices(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/cla_wide_add_ctrl_if.sv
// Operand request / result response handshake bundle of the wide adder controller.
interface cla_wide_add_ctrl_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, overflow, busy);
endinterface

// File: rtl/cla_wide_add_ctrl_slice_shifter.sv
// Operand and result shift registers; one slice moves per shift pulse, LS slice first.
module cla_slice_shifter
  import cla_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [SLICE_W-1:0] slice_sum,
  output logic [SLICE_W-1:0] a_nxt,
  output logic [SLICE_W-1:0] b_nxt,
  output logic [WIDTH-1:0]   sum_nxt
);
  logic [WIDTH-1:0]         a_sh, b_sh, sum_sh, a_shr, b_shr;
  logic [WIDTH+SLICE_W-1:0] sum_cat;

  assign a_shr   = a_sh >> SLICE_W;
  assign b_shr   = b_sh >> SLICE_W;
  assign a_nxt   = a_shr[SLICE_W-1:0];
  assign b_nxt   = b_shr[SLICE_W-1:0];
  // New slice enters at the top; after NSLICES shifts the word is in place.
  assign sum_cat = {slice_sum, sum_sh};
  assign sum_nxt = sum_cat[WIDTH+SLICE_W-1:SLICE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
    end else if (load) begin
      a_sh   <= a_in;
      b_sh   <= b_in;
      sum_sh <= '0;
    end else if (shift) begin
      a_sh   <= a_shr;
      b_sh   <= b_shr;
      sum_sh <= sum_nxt;
    end
  end
endmodule

// File: rtl/cla_wide_add_ctrl.sv
// Sequences a WIDTH-bit add over an external 8-bit CLA, one slice per SLICE_CYCLES cycles.
module cla_wide_add_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SLICE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_wide_add_ctrl_if.slave io,
  output logic [SLICE_W-1:0] cla_a,
  output logic [SLICE_W-1:0] cla_b,
  output logic               cla_cin,
  input  logic [SLICE_W-1:0] cla_sum,
  input  logic               cla_cout
);
  localparam int NSLICES = nslices(WIDTH);
  localparam int CW      = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam int IW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W || SLICE_CYCLES < 1) begin : g_bad_param
    $error("cla_wide_add_ctrl: WIDTH must be a multiple of 8 and SLICE_CYCLES >= 1");
  end

  cla_ctrl_state_t    state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic               a_msb_q, b_msb_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q, out_valid_q;
  logic [SLICE_W-1:0] cla_a_q, cla_b_q;
  logic               carry_q;
  logic               accept, capture, last, in_ready_c;
  logic [SLICE_W-1:0] a_nxt, b_nxt;
  logic [WIDTH-1:0]   sum_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    last       = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (io.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(SLICE_CYCLES-1)) begin
          capture = 1'b1;
          if (idx_q == IW'(NSLICES-1)) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  cla_slice_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (capture),
    .a_in      (io.a),
    .b_in      (io.b),
    .slice_sum (cla_sum),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .sum_nxt   (sum_nxt)
  );

  // carry_q doubles as the registered cla_cin; it is cleared on the final
  // capture so the CLA inputs read 0 outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cla_a_q     <= '0;
      cla_b_q     <= '0;
      carry_q     <= 1'b0;
    end else if (accept) begin
      a_msb_q <= io.a[WIDTH-1];
      b_msb_q <= io.b[WIDTH-1];
      cnt_q   <= '0;
      idx_q   <= '0;
      cla_a_q <= io.a[SLICE_W-1:0];
      cla_b_q <= io.b[SLICE_W-1:0];
      carry_q <= io.cin;
    end else if (capture) begin
      cnt_q <= '0;
      idx_q <= idx_q + IW'(1);
      if (last) begin
        sum_q       <= sum_nxt;
        cout_q      <= cla_cout;
        ovf_q       <= (a_msb_q == b_msb_q) && (sum_nxt[WIDTH-1] != a_msb_q);
        out_valid_q <= 1'b1;
        cla_a_q     <= '0;
        cla_b_q     <= '0;
        carry_q     <= 1'b0;
      end else begin
        cla_a_q <= a_nxt;
        cla_b_q <= b_nxt;
        carry_q <= cla_cout;
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == DONE && io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.overflow  = ovf_q;
  assign cla_a        = cla_a_q;
  assign cla_b        = cla_b_q;
  assign cla_cin      = carry_q;
endmodule

// File: tb/tb_cla_wide_add_ctrl.sv
// Directed bench: two controllers (1 and 3 cycles per slice) on behavioural 8-bit adders.
module tb_cla_wide_add_ctrl;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_wide_add_ctrl_if #(.WIDTH(32)) io0 ();
  cla_wide_add_ctrl_if #(.WIDTH(32)) io1 ();
  logic [7:0] cla_a0, cla_b0, cla_sum0, cla_a1, cla_b1, cla_sum1;
  logic       cla_cin0, cla_cout0, cla_cin1, cla_cout1;

  assign {cla_cout0, cla_sum0} = {1'b0, cla_a0} + {1'b0, cla_b0} + {8'd0, cla_cin0};
  assign {cla_cout1, cla_sum1} = {1'b0, cla_a1} + {1'b0, cla_b1} + {8'd0, cla_cin1};

  cla_wide_add_ctrl #(.WIDTH(32), .SLICE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .io(io0), .cla_a(cla_a0), .cla_b(cla_b0),
    .cla_cin(cla_cin0), .cla_sum(cla_sum0), .cla_cout(cla_cout0));
  cla_wide_add_ctrl #(.WIDTH(32), .SLICE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .io(io1), .cla_a(cla_a1), .cla_b(cla_b1),
    .cla_cin(cla_cin1), .cla_sum(cla_sum1), .cla_cout(cla_cout1));

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  logic [7:0] a_log[64];
  logic       cin_log[64];
  int         nlog;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_sum(int w); return (w == 1) ? io1.sum : io0.sum; endfunction
  function automatic logic g_ov(int w); return (w == 1) ? io1.out_valid : io0.out_valid; endfunction
  function automatic logic g_ir(int w); return (w == 1) ? io1.in_ready : io0.in_ready; endfunction
  function automatic logic g_cout(int w); return (w == 1) ? io1.cout : io0.cout; endfunction
  function automatic logic g_ovf(int w); return (w == 1) ? io1.overflow : io0.overflow; endfunction
  function automatic logic g_busy(int w); return (w == 1) ? io1.busy : io0.busy; endfunction
  function automatic logic [7:0] g_cla_a(int w); return (w == 1) ? cla_a1 : cla_a0; endfunction
  function automatic logic g_cla_cin(int w); return (w == 1) ? cla_cin1 : cla_cin0; endfunction

  task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    if (w == 1) begin io1.in_valid = v; io1.a = a; io1.b = b; io1.cin = c; end
    else        begin io0.in_valid = v; io0.a = a; io0.b = b; io0.cin = c; end
  endtask

  task automatic set_ready(input int w, input logic r);
    if (w == 1) io1.out_ready = r; else io0.out_ready = r;
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    res_t r;
    logic [32:0] t;
    t   = {1'b0, a} + {1'b0, b} + {32'd0, c};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (a[31] == b[31]) && (t[31] != a[31]);
    return r;
  endfunction

  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                    input int hold, input bit pulse);
    res_t exp, got;
    int   lat, sc;
    sc  = (w == 1) ? 3 : 1;
    lat = 0;
    nlog = 0;
    @(negedge clk);
    drive(w, 1'b1, a, b, c);
    sb_q.push_back(model(a, b, c));
    check("in_ready_idle", 64'(g_ir(w)), 64'd1);
    @(posedge clk); #1;
    drive(w, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      if (!g_ov(w) && nlog < 64) begin
        a_log[nlog] = g_cla_a(w); cin_log[nlog] = g_cla_cin(w); nlog++;
      end
      if (pulse && k == 2) begin
        drive(w, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
        check("in_ready_run", 64'(g_ir(w)), 64'd0);
      end
      @(posedge clk); #1;
      if (pulse && k == 2) drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
      if (g_ov(w)) begin lat = k + 1; break; end
    end
    check("latency", 64'(lat), 64'(4 * sc + 1));
    exp = sb_q.pop_front();
    got = '{s: g_sum(w), c: g_cout(w), o: g_ovf(w)};
    check("sum", 64'(got.s), 64'(exp.s));
    check("cout", 64'(got.c), 64'(exp.c));
    check("overflow", 64'(got.o), 64'(exp.o));
    check("cla_a_done", 64'(g_cla_a(w)), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(g_ov(w)), 64'd1);
      check("bp_sum", 64'(g_sum(w)), 64'(exp.s));
      check("bp_in_ready", 64'(g_ir(w)), 64'd0);
    end
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    set_ready(w, 1'b0);
    check("post_hs_out_valid", 64'(g_ov(w)), 64'd0);
    check("post_hs_in_ready", 64'(g_ir(w)), 64'd1);
  endtask

  initial begin
    bit seen;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(io0.in_ready), 64'd1);
    check("rst_out_valid", 64'(io0.out_valid), 64'd0);
    check("rst_busy", 64'(io0.busy), 64'd0);
    check("rst_sum", 64'(io0.sum), 64'd0);
    check("rst_cla", 64'({cla_a0, cla_b0, cla_cin0}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 32'h00000001, 32'h00000002, 1'b0, 0, 1'b0);
    op(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    check("cin_slice0", 64'(cin_log[0]), 64'd0);
    check("cin_slice1", 64'(cin_log[1]), 64'd1);
    check("cin_slice2", 64'(cin_log[2]), 64'd1);
    check("cin_slice3", 64'(cin_log[3]), 64'd1);
    op(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    op(0, 32'h80000000, 32'h80000000, 1'b0, 0, 1'b0);
    op(0, 32'hDEADBEEF, 32'h01234567, 1'b1, 3, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("no_second_accept", 64'({io0.out_valid, io0.busy}), 64'd0);

    // Reset landing in the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_rst_busy", 64'(io0.busy), 64'd0);
    check("midrun_rst_in_ready", 64'(io0.in_ready), 64'd1);
    check("midrun_rst_outs", 64'({io0.out_valid, io0.sum, io0.cout, io0.overflow}), 64'd0);
    check("midrun_rst_cla", 64'({cla_a0, cla_b0, cla_cin0}), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (io0.out_valid) seen = 1'b1;
    end
    check("midrun_rst_no_result", 64'(seen), 64'd0);
    op(0, 32'h12345678, 32'h11111111, 1'b0, 0, 1'b0);

    op(1, 32'h00FF00FF, 32'h00010001, 1'b1, 0, 1'b0);
    check("sc3_nlog", 64'(nlog), 64'd12);
    for (int i = 0; i < 12; i++)
      check($sformatf("sc3_cla_a_%0d", i), 64'(a_log[i]), ((i / 3) % 2 == 0) ? 64'hFF : 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
